// File: rtl/ifft8_pkg.sv
// Shared widths, conjugated twiddles, FSM states and index helpers for the 8-point serial IFFT.
package ifft8_pkg;

  localparam int DEF_DW   = 24;
  localparam int DEF_TW   = 16;
  localparam int DEF_FRAC = 13;
  localparam int CP_LEN   = 2;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  typedef struct packed {
    logic signed [DEF_TW-1:0] re;
    logic signed [DEF_TW-1:0] im;
  } twiddle_t;

  // Inverse direction: e^{+j*2*pi*k/8} in Q13
  localparam twiddle_t TWIDDLE [4] = '{
    '{re: 16'sh2000, im: 16'sh0000},
    '{re: 16'sh16A0, im: 16'sh16A0},
    '{re: 16'sh0000, im: 16'sh2000},
    '{re: 16'shE960, im: 16'sh16A0}
  };

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/ifft8_serial_if.sv
// Input bin stream, output sample stream and status of the serial IFFT.
interface ifft8_serial_if #(parameter int DW = ifft8_pkg::DEF_DW);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_real;
  logic signed [DW-1:0] in_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_real;
  logic signed [DW-1:0] out_imag;
  logic [2:0]           out_index;
  logic                 out_last;
  logic                 busy;

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_index, out_last, busy
  );

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_index, out_last, busy
  );

endinterface

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly with twiddle multiply and a 1/2 scale on both outputs.
module ifft_butterfly #(
  parameter int DW   = ifft8_pkg::DEF_DW,
  parameter int TW   = ifft8_pkg::DEF_TW,
  parameter int FRAC = ifft8_pkg::DEF_FRAC
) (
  input  logic signed [DW-1:0] p_re,
  input  logic signed [DW-1:0] p_im,
  input  logic signed [DW-1:0] q_re,
  input  logic signed [DW-1:0] q_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output logic signed [DW-1:0] pn_re,
  output logic signed [DW-1:0] pn_im,
  output logic signed [DW-1:0] qn_re,
  output logic signed [DW-1:0] qn_im
);

  localparam int PW = DW + TW;

  logic signed [PW:0] sum_re;
  logic signed [PW:0] sum_im;
  logic signed [DW:0] t_re;
  logic signed [DW:0] t_im;

  assign sum_re = (PW+1)'(PW'(q_re) * PW'(w_re)) - (PW+1)'(PW'(q_im) * PW'(w_im));
  assign sum_im = (PW+1)'(PW'(q_re) * PW'(w_im)) + (PW+1)'(PW'(q_im) * PW'(w_re));

  // Floor shift back to sample scale; one guard bit kept for the add/sub
  assign t_re = (DW+1)'(sum_re >>> FRAC);
  assign t_im = (DW+1)'(sum_im >>> FRAC);

  assign pn_re = DW'(((DW+2)'(p_re) + (DW+2)'(t_re)) >>> 1);
  assign pn_im = DW'(((DW+2)'(p_im) + (DW+2)'(t_im)) >>> 1);
  assign qn_re = DW'(((DW+2)'(p_re) - (DW+2)'(t_re)) >>> 1);
  assign qn_im = DW'(((DW+2)'(p_im) - (DW+2)'(t_im)) >>> 1);

endmodule

// File: rtl/ifft8_serial.sv
// 8-point iterative radix-2 IFFT: serial load, 12 shared-butterfly cycles, serial unload.
// Define IFFT8_CP_EN to prepend a 2-sample cyclic prefix to each output frame.
module ifft8_serial #(
  parameter int DW   = ifft8_pkg::DEF_DW,
  parameter int TW   = ifft8_pkg::DEF_TW,
  parameter int FRAC = ifft8_pkg::DEF_FRAC
) (
  input logic          clk,
  input logic          rst,
  ifft8_serial_if.slave bus
);

  import ifft8_pkg::*;

`ifdef IFFT8_CP_EN
  localparam int OUT_LEN = 8 + CP_LEN;
`else
  localparam int OUT_LEN = 8;
`endif
  localparam logic [3:0] OUT_LAST_CNT = 4'(OUT_LEN - 1);

  state_t               state;
  logic [2:0]           load_cnt;
  logic [3:0]           bf_cnt;
  logic [3:0]           out_cnt;
  logic signed [DW-1:0] mem_re [8];
  logic signed [DW-1:0] mem_im [8];
  logic signed [DW-1:0] out_real_q, out_imag_q;
  logic [2:0]           out_index_q;
  logic                 out_last_q;

  logic                 in_ready, in_hs, out_hs;
  logic [1:0]           stage, unit, tw_idx;
  logic [2:0]           top_idx, bot_idx;
  logic [3:0]           next_cnt;
  logic [2:0]           next_idx, first_idx;
  logic signed [DW-1:0] pn_re, pn_im, qn_re, qn_im;

  // With the prefix enabled the unload count starts CP_LEN samples before index 0
  function automatic logic [2:0] sample_index(input logic [3:0] cnt);
`ifdef IFFT8_CP_EN
    return 3'(cnt + 4'(8 - CP_LEN));
`else
    return 3'(cnt);
`endif
  endfunction

  assign in_ready  = (state == LOAD) && !rst;
  assign in_hs     = bus.in_valid && in_ready;
  assign out_hs    = (state == UNLOAD) && bus.out_ready;
  assign stage     = bf_cnt[3:2];
  assign unit      = bf_cnt[1:0];
  assign next_cnt  = out_cnt + 4'd1;
  assign next_idx  = sample_index(next_cnt);
  assign first_idx = sample_index(4'd0);

  always_comb begin
    top_idx = '0;
    bot_idx = '0;
    tw_idx  = '0;
    case (stage)
      2'd0: begin
        top_idx = {unit, 1'b0};
        bot_idx = {unit, 1'b1};
        tw_idx  = 2'd0;
      end
      2'd1: begin
        top_idx = {unit[1], 1'b0, unit[0]};
        bot_idx = {unit[1], 1'b1, unit[0]};
        tw_idx  = {unit[0], 1'b0};
      end
      default: begin
        top_idx = {1'b0, unit};
        bot_idx = {1'b1, unit};
        tw_idx  = unit;
      end
    endcase
  end

  ifft_butterfly #(.DW(DW), .TW(TW), .FRAC(FRAC)) u_bfly (
    .p_re (mem_re[top_idx]),
    .p_im (mem_im[top_idx]),
    .q_re (mem_re[bot_idx]),
    .q_im (mem_im[bot_idx]),
    .w_re (TW'(TWIDDLE[tw_idx].re)),
    .w_im (TW'(TWIDDLE[tw_idx].im)),
    .pn_re(pn_re),
    .pn_im(pn_im),
    .qn_re(qn_re),
    .qn_im(qn_im)
  );

  // Register file needs no reset: a new frame overwrites all eight entries
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem_re[bitrev3(load_cnt)] <= bus.in_real;
      mem_im[bitrev3(load_cnt)] <= bus.in_imag;
    end else if (state == COMPUTE) begin
      mem_re[top_idx] <= pn_re;
      mem_im[top_idx] <= pn_im;
      mem_re[bot_idx] <= qn_re;
      mem_im[bot_idx] <= qn_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      load_cnt    <= '0;
      bf_cnt      <= '0;
      out_cnt     <= '0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_hs) begin
            load_cnt <= load_cnt + 3'd1;
            if (load_cnt == 3'd7) state <= COMPUTE;
          end
        end
        COMPUTE: begin
          bf_cnt <= bf_cnt + 4'd1;
          // First sample's entry is already final when the last butterfly retires
          if (bf_cnt == 4'd11) begin
            bf_cnt      <= '0;
            state       <= UNLOAD;
            out_cnt     <= '0;
            out_index_q <= first_idx;
            out_real_q  <= mem_re[first_idx];
            out_imag_q  <= mem_im[first_idx];
            out_last_q  <= 1'b0;
          end
        end
        UNLOAD: begin
          if (out_hs) begin
            if (out_cnt == OUT_LAST_CNT) begin
              state       <= LOAD;
              out_cnt     <= '0;
              out_real_q  <= '0;
              out_imag_q  <= '0;
              out_index_q <= '0;
              out_last_q  <= 1'b0;
            end else begin
              out_cnt     <= next_cnt;
              out_index_q <= next_idx;
              out_real_q  <= mem_re[next_idx];
              out_imag_q  <= mem_im[next_idx];
              out_last_q  <= (next_cnt == OUT_LAST_CNT);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == UNLOAD);
  assign bus.out_real  = out_real_q;
  assign bus.out_imag  = out_imag_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state != LOAD);

endmodule

// File: tb/tb_ifft8_serial.sv
// Directed bench for ifft8_serial: impulse, DC, tone, backpressure and mid-compute reset frames.
module tb_ifft8_serial;

  localparam int DW = 24;
`ifdef IFFT8_CP_EN
  localparam int N_OUT   = 10;
  localparam int IDX_OFS = 6;
`else
  localparam int N_OUT   = 8;
  localparam int IDX_OFS = 0;
`endif

  typedef logic signed [DW-1:0] samp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  samp_t      fr_re [8];
  samp_t      fr_im [8];
  samp_t      got_re [10];
  samp_t      got_im [10];
  logic [2:0] got_idx [10];
  logic       got_last [10];
  int         got_n;
  int         got_lat;

  // Ideal 1000*e^{+j*2*pi*n/8}
  int ideal_re [8] = '{1000, 707, 0, -707, -1000, -707, 0, 707};
  int ideal_im [8] = '{0, 707, 1000, 707, 0, -707, -1000, -707};

  ifft8_serial_if #(.DW(DW)) bus ();

  ifft8_serial dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_frame();
    for (int i = 0; i < 8; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  // Returns just after the posedge of the 8th input handshake
  task automatic send_frame(input bit with_gaps, output bit ok);
    int wait_cnt;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (with_gaps && (i % 3 == 1)) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_real  = fr_re[i];
      bus.in_imag  = fr_im[i];
      wait_cnt = 0;
      while (!bus.in_ready && wait_cnt < 100) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (!bus.in_ready) begin
        bus.in_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      @(posedge clk);
    end
  endtask

  // got_lat counts negedges from the last input handshake; 13 means the first output handshake edge is T+13
  task automatic collect_frame(output bit ok);
    got_n = 0;
    got_lat = -1;
    ok = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = 1; j <= 200 && !ok; j++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        if (got_lat < 0) got_lat = j;
        got_re[got_n]   = bus.out_real;
        got_im[got_n]   = bus.out_imag;
        got_idx[got_n]  = bus.out_index;
        got_last[got_n] = bus.out_last;
        got_n++;
        if (bus.out_last || got_n == 10) ok = 1'b1;
      end
    end
    if (ok) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready_during_rst: got %b, expected 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy); end
    checks++;
    if (bus.out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %b, expected 0", bus.out_last); end
    checks++;
    if (bus.out_real !== 0 || bus.out_imag !== 0) begin errors++; $display("[TB] FAIL reset_out_data: got (%0d,%0d), expected (0,0)", bus.out_real, bus.out_imag); end
    checks++;
    if (bus.out_index !== 3'd0) begin errors++; $display("[TB] FAIL reset_out_index: got %0d, expected 0", bus.out_index); end
  endtask

  task automatic test_impulse(input string tag);
    bit ok;
    clear_frame();
    fr_re[0] = 24'sd8192;
    send_frame(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL %s_send: got timeout, expected 8 handshakes", tag); return; end
    collect_frame(ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL %s_collect: got %0d samples and timeout, expected %0d", tag, got_n, N_OUT); return; end
    checks++;
    if (got_lat != 13) begin errors++; $display("[TB] FAIL %s_latency: got %0d, expected 13", tag, got_lat); end
    checks++;
    if (got_n != N_OUT) begin errors++; $display("[TB] FAIL %s_count: got %0d, expected %0d", tag, got_n, N_OUT); end
    for (int n = 0; n < got_n; n++) begin
      checks++;
      if (got_re[n] !== 24'sd1024 || got_im[n] !== 24'sd0) begin
        errors++; $display("[TB] FAIL %s_value[%0d]: got (%0d,%0d), expected (1024,0)", tag, n, got_re[n], got_im[n]);
      end
      checks++;
      if (got_idx[n] !== 3'(n + IDX_OFS)) begin errors++; $display("[TB] FAIL %s_index[%0d]: got %0d, expected %0d", tag, n, got_idx[n], 3'(n + IDX_OFS)); end
      checks++;
      if (got_last[n] !== (n == N_OUT - 1)) begin errors++; $display("[TB] FAIL %s_last[%0d]: got %b, expected %b", tag, n, got_last[n], (n == N_OUT - 1)); end
    end
  endtask

  task automatic test_dc();
    bit ok;
    int exp_re;
    logic [2:0] e;
    for (int i = 0; i < 8; i++) begin
      fr_re[i] = 24'sd800;
      fr_im[i] = '0;
    end
    send_frame(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL dc_send: got timeout, expected 8 handshakes"); return; end
    collect_frame(ok);
    checks++;
    if (!ok || got_n != N_OUT) begin errors++; $display("[TB] FAIL dc_count: got %0d, expected %0d", got_n, N_OUT); return; end
    for (int n = 0; n < N_OUT; n++) begin
      e = 3'(n + IDX_OFS);
      exp_re = (e == 3'd0) ? 800 : 0;
      checks++;
      if (got_idx[n] !== e || int'(got_re[n]) != exp_re || got_im[n] !== 24'sd0) begin
        errors++; $display("[TB] FAIL dc_sample[%0d]: got idx %0d (%0d,%0d), expected idx %0d (%0d,0)", n, got_idx[n], got_re[n], got_im[n], e, exp_re);
      end
    end
  endtask

  task automatic test_tone();
    bit ok;
    int dr, di;
    logic [2:0] e;
    clear_frame();
    fr_re[1] = 24'sd8000;
    send_frame(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL tone_send: got timeout, expected 8 handshakes"); return; end
    collect_frame(ok);
    checks++;
    if (!ok || got_n != N_OUT) begin errors++; $display("[TB] FAIL tone_count: got %0d, expected %0d", got_n, N_OUT); return; end
    for (int n = 0; n < N_OUT; n++) begin
      e = 3'(n + IDX_OFS);
      dr = int'(got_re[n]) - ideal_re[e];
      di = int'(got_im[n]) - ideal_im[e];
      checks++;
      if (got_idx[n] !== e || dr > 2 || dr < -2 || di > 2 || di < -2) begin
        errors++; $display("[TB] FAIL tone_sample[%0d]: got idx %0d (%0d,%0d), expected idx %0d (%0d,%0d) +-2", n, got_idx[n], got_re[n], got_im[n], e, ideal_re[e], ideal_im[e]);
      end
      checks++;
      if (got_last[n] !== (n == N_OUT - 1)) begin errors++; $display("[TB] FAIL tone_last[%0d]: got %b, expected %b", n, got_last[n], (n == N_OUT - 1)); end
    end
  endtask

  task automatic test_back_to_back_backpressure();
    bit ok;
    bit stalled;
    bit done;
    int dr, di;
    samp_t hold_re, hold_im;
    logic [2:0] hold_idx;
    logic [2:0] e;
    clear_frame();
    fr_re[1] = 24'sd8000;
    send_frame(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL bp_send: got timeout, expected 8 handshakes"); return; end
    got_n = 0;
    stalled = 1'b0;
    done = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 300 && !done; j++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (got_n == 3 && !stalled) begin
        stalled = 1'b1;
        bus.out_ready = 1'b0;
        hold_re  = bus.out_real;
        hold_im  = bus.out_imag;
        hold_idx = bus.out_index;
        checks++;
        if (hold_idx !== 3'(3 + IDX_OFS)) begin errors++; $display("[TB] FAIL bp_stall_index: got %0d, expected %0d", hold_idx, 3'(3 + IDX_OFS)); end
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if (bus.out_real !== hold_re || bus.out_imag !== hold_im || bus.out_index !== hold_idx || bus.out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_hold[%0d]: got v%b idx %0d (%0d,%0d), expected v1 idx %0d (%0d,%0d)", k, bus.out_valid, bus.out_index, bus.out_real, bus.out_imag, hold_idx, hold_re, hold_im);
          end
          checks++;
          if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b, expected 0", k, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid) begin
        got_re[got_n]   = bus.out_real;
        got_im[got_n]   = bus.out_imag;
        got_idx[got_n]  = bus.out_index;
        got_last[got_n] = bus.out_last;
        got_n++;
        if (bus.out_last || got_n == 10) done = 1'b1;
      end
    end
    if (done) @(posedge clk);
    checks++;
    if (got_n != N_OUT) begin errors++; $display("[TB] FAIL bp_count: got %0d, expected %0d", got_n, N_OUT); return; end
    for (int n = 0; n < N_OUT; n++) begin
      e = 3'(n + IDX_OFS);
      dr = int'(got_re[n]) - ideal_re[e];
      di = int'(got_im[n]) - ideal_im[e];
      checks++;
      if (got_idx[n] !== e || dr > 2 || dr < -2 || di > 2 || di < -2) begin
        errors++; $display("[TB] FAIL bp_sample[%0d]: got idx %0d (%0d,%0d), expected idx %0d (%0d,%0d) +-2", n, got_idx[n], got_re[n], got_im[n], e, ideal_re[e], ideal_im[e]);
      end
    end
  endtask

  task automatic test_reset_mid_compute();
    bit ok;
    clear_frame();
    fr_re[1] = 24'sd8000;
    send_frame(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL rmc_send: got timeout, expected 8 handshakes"); return; end
    repeat (6) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL rmc_busy_before: got %b, expected 1", bus.busy); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmc_in_ready: got %b, expected 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmc_out_valid: got %b, expected 0", bus.out_valid); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rmc_busy: got %b, expected 0", bus.busy); end
    test_impulse("rmc_impulse");
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_impulse("impulse");
    test_dc();
    test_tone();
    test_back_to_back_backpressure();
    test_reset_mid_compute();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
